// File: rtl/mem1_pkg.sv
// Shared widths, FSM encoding and access-context type for the mem1 memory-access stage.
// The lane one-hot helper is shared by the aligner and anything decoding byte enables.
package mem1_pkg;

  localparam int unsigned REG_SIZE    = 32;
  localparam int unsigned ADDR_SIZE   = 32;
  localparam int unsigned REG_ADDR    = 5;
  localparam int unsigned MEM_BE_W    = 4;
  localparam int unsigned MEM_TIMEOUT = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

  // What the write-back side needs to remember about the access in flight.
  typedef struct packed {
    logic                load;
    logic                byte_acc;
    logic [1:0]          lane;
    logic                regwrite;
    logic [REG_ADDR-1:0] wreg;
  } acc_ctx_t;

  function automatic logic [MEM_BE_W-1:0] lane_onehot(input logic [1:0] lane);
    return MEM_BE_W'(1) << lane;
  endfunction

endpackage

// File: rtl/mem1_if.sv
// Data-memory request/acknowledge port between the mem1 stage (master) and memory (slave).
interface mem1_if;
  import mem1_pkg::*;

  logic                 req;
  logic                 we;
  logic [MEM_BE_W-1:0]  be;
  logic [ADDR_SIZE-1:0] addr;
  logic [REG_SIZE-1:0]  wdata;
  logic [REG_SIZE-1:0]  rdata;
  logic                 ack;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/mem1_align.sv
// Combinational lane handling: store byte enables and lane replication, load byte select
// with sign extension.
module mem1_align
  import mem1_pkg::*;
(
  input  logic                st_byte,
  input  logic [1:0]          st_lane,
  input  logic [REG_SIZE-1:0] st_data,
  output logic [MEM_BE_W-1:0] st_be,
  output logic [REG_SIZE-1:0] st_wdata,
  input  logic                ld_byte,
  input  logic [1:0]          ld_lane,
  input  logic [REG_SIZE-1:0] ld_rdata,
  output logic [REG_SIZE-1:0] ld_data
);

  logic [7:0] ld_b;

  always_comb begin
    st_be    = st_byte ? lane_onehot(st_lane) : '1;
    st_wdata = st_byte ? {4{st_data[7:0]}} : st_data;

    ld_b = ld_rdata[7:0];
    unique case (ld_lane)
      2'd0: ld_b = ld_rdata[7:0];
      2'd1: ld_b = ld_rdata[15:8];
      2'd2: ld_b = ld_rdata[23:16];
      2'd3: ld_b = ld_rdata[31:24];
      default: ld_b = ld_rdata[7:0];
    endcase

    ld_data = ld_byte ? {{(REG_SIZE - 8){ld_b[7]}}, ld_b} : ld_rdata;
  end

endmodule

// File: rtl/mem1.sv
// Memory-access stage: IDLE/WAIT FSM issuing word/byte accesses over a req/ack port with a
// timeout, producing a registered one-cycle write-back bundle per instruction.
module mem1
  import mem1_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                memread,
  input  logic                memwrite,
  input  logic                membyte,
  input  logic [REG_SIZE-1:0] alu_result,
  input  logic [REG_SIZE-1:0] data_store,
  input  logic                regwrite_in,
  input  logic [REG_ADDR-1:0] wreg_in,
  output logic                stall,
  mem1_if.master              mem,
  output logic                wb_valid,
  output logic                wb_regwrite,
  output logic [REG_SIZE-1:0] wb_data,
  output logic [REG_ADDR-1:0] wb_reg,
  output logic                exc_misaligned,
  output logic                exc_bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  mem_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  acc_ctx_t ctx_q, ctx_d;

  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [MEM_BE_W-1:0]  be_q, be_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [REG_SIZE-1:0]  wdata_q, wdata_d;

  logic                wb_valid_q, wb_valid_d;
  logic                wb_rw_q, wb_rw_d;
  logic [REG_SIZE-1:0] wb_data_q, wb_data_d;
  logic [REG_ADDR-1:0] wb_reg_q, wb_reg_d;
  logic                exc_mis_q, exc_mis_d;
  logic                exc_bus_q, exc_bus_d;

  logic                is_mem;
  logic                misaligned;
  logic [MEM_BE_W-1:0] st_be;
  logic [REG_SIZE-1:0] st_wdata;
  logic [REG_SIZE-1:0] ld_data;

  mem1_align u_align (
    .st_byte  (membyte),
    .st_lane  (alu_result[1:0]),
    .st_data  (data_store),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_byte  (ctx_q.byte_acc),
    .ld_lane  (ctx_q.lane),
    .ld_rdata (mem.rdata),
    .ld_data  (ld_data)
  );

  assign is_mem     = memread | memwrite;
  assign misaligned = !membyte && (alu_result[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctx_d      = ctx_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    exc_mis_d  = 1'b0;
    exc_bus_d  = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_data_d  = wb_data_q;
    wb_reg_d   = wb_reg_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result;
            wb_reg_d   = wreg_in;
            wb_rw_d    = regwrite_in;
          end else if (misaligned) begin
            // Faulting address goes out on wb_data for the exception handler.
            wb_valid_d = 1'b1;
            exc_mis_d  = 1'b1;
            wb_rw_d    = 1'b0;
            wb_data_d  = alu_result;
            wb_reg_d   = wreg_in;
          end else begin
            state_d        = StWait;
            cnt_d          = '0;
            req_d          = 1'b1;
            we_d           = !memread;
            be_d           = st_be;
            addr_d         = {alu_result[ADDR_SIZE-1:2], 2'b00};
            wdata_d        = st_wdata;
            ctx_d.load     = memread;
            ctx_d.byte_acc = membyte;
            ctx_d.lane     = alu_result[1:0];
            ctx_d.regwrite = regwrite_in;
            ctx_d.wreg     = wreg_in;
          end
        end
      end
      StWait: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (mem.ack) begin
          state_d    = StIdle;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_reg_d   = ctx_q.wreg;
          wb_rw_d    = ctx_q.load ? ctx_q.regwrite : 1'b0;
          wb_data_d  = ctx_q.load ? ld_data : '0;
        end else if (cnt_q == CntLast) begin
          state_d    = StIdle;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          exc_bus_d  = 1'b1;
          wb_rw_d    = 1'b0;
          wb_data_d  = '0;
          wb_reg_d   = ctx_q.wreg;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ctx_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_reg_q   <= '0;
      exc_mis_q  <= 1'b0;
      exc_bus_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctx_q      <= ctx_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_data_q  <= wb_data_d;
      wb_reg_q   <= wb_reg_d;
      exc_mis_q  <= exc_mis_d;
      exc_bus_q  <= exc_bus_d;
    end
  end

  assign stall          = (state_q != StIdle);
  assign mem.req        = req_q;
  assign mem.we         = we_q;
  assign mem.be         = be_q;
  assign mem.addr       = addr_q;
  assign mem.wdata      = wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_regwrite    = wb_rw_q;
  assign wb_data        = wb_data_q;
  assign wb_reg         = wb_reg_q;
  assign exc_misaligned = exc_mis_q;
  assign exc_bus        = exc_bus_q;

endmodule

// File: tb/tb_mem1.sv
// Self-checking bench for mem1: directed scenarios plus randomized instructions compared
// against a transaction-level reference model.
module tb_mem1;
  import mem1_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, memread, memwrite, membyte, regwrite_in;
  logic [31:0] alu_result, data_store;
  logic [4:0]  wreg_in;
  logic        stall, wb_valid, wb_regwrite, exc_misaligned, exc_bus;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem1_if mem_bus ();

  mem1 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .memread        (memread),
    .memwrite       (memwrite),
    .membyte        (membyte),
    .alu_result     (alu_result),
    .data_store     (data_store),
    .regwrite_in    (regwrite_in),
    .wreg_in        (wreg_in),
    .stall          (stall),
    .mem            (mem_bus),
    .wb_valid       (wb_valid),
    .wb_regwrite    (wb_regwrite),
    .wb_data        (wb_data),
    .wb_reg         (wb_reg),
    .exc_misaligned (exc_misaligned),
    .exc_bus        (exc_bus)
  );

  // Observable outcome of one instruction.
  typedef struct packed {
    logic [7:0]  req_cycles;
    logic [7:0]  stall_cycles;
    logic [7:0]  lat;
    logic        wb_seen;
    logic [31:0] wb_data;
    logic        wb_rw;
    logic [4:0]  wb_reg;
    logic        mis;
    logic        bus;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stable;
    logic        pulse_ok;
  } res_t;

  function automatic res_t model(input logic rd, input logic wr, input logic by,
                                 input logic [31:0] addr, input logic [31:0] ds,
                                 input logic [31:0] rdata, input logic rw,
                                 input logic [4:0] wreg, input int ack_lat);
    res_t e;
    int   lane;
    int   b;
    e = '0;
    e.wb_seen  = 1'b1;
    e.stable   = 1'b1;
    e.pulse_ok = 1'b1;
    lane = int'(addr % 4);
    if (!(rd || wr)) begin
      e.lat = 8'd1; e.wb_data = addr; e.wb_rw = rw; e.wb_reg = wreg;
      return e;
    end
    if (!by && lane != 0) begin
      e.lat = 8'd1; e.mis = 1'b1;
      return e;
    end
    e.we    = !rd;
    e.be    = by ? 4'(1 << lane) : 4'hF;
    e.addr  = addr - 32'(lane);
    e.wdata = by ? 32'(ds[7:0]) * 32'h0101_0101 : ds;
    if (ack_lat < 1 || ack_lat > TO) begin
      e.req_cycles = 8'(TO); e.stall_cycles = 8'(TO); e.lat = 8'(TO + 1); e.bus = 1'b1;
      return e;
    end
    e.req_cycles   = 8'(ack_lat);
    e.stall_cycles = 8'(ack_lat);
    e.lat          = 8'(ack_lat + 1);
    if (rd) begin
      e.wb_rw  = rw;
      e.wb_reg = wreg;
      if (by) begin
        b = int'((rdata >> (8 * lane)) & 32'hFF);
        e.wb_data = (b >= 128) ? 32'(b - 256) : 32'(b);
      end else begin
        e.wb_data = rdata;
      end
    end
    return e;
  endfunction

  // Drives one instruction, acts as the memory (ack on the ack_lat-th request cycle, 0 = never),
  // and records what the DUT did. Starts and ends #1 after a rising edge.
  task automatic run_op(input logic rd, input logic wr, input logic by,
                        input logic [31:0] addr, input logic [31:0] ds,
                        input logic [31:0] rdata, input logic rw, input logic [4:0] wreg,
                        input int ack_lat, input logic junk_ack, output res_t o);
    int n;
    o = '0;
    o.stable   = 1'b1;
    o.pulse_ok = 1'b1;
    memread = rd; memwrite = wr; membyte = by; alu_result = addr; data_store = ds;
    regwrite_in = rw; wreg_in = wreg; in_valid = 1'b1;
    mem_bus.ack = junk_ack; mem_bus.rdata = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    memread = 1'($urandom); memwrite = 1'($urandom); alu_result = $urandom;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      mem_bus.ack = 1'b0;
      mem_bus.rdata = $urandom;
      if (stall) o.stall_cycles++;
      if (mem_bus.req) begin
        n++;
        if (n == 1) begin
          o.we = mem_bus.we; o.be = mem_bus.be; o.addr = mem_bus.addr; o.wdata = mem_bus.wdata;
        end else if ({mem_bus.we, mem_bus.be, mem_bus.addr, mem_bus.wdata} !==
                     {o.we, o.be, o.addr, o.wdata}) begin
          o.stable = 1'b0;
        end
        if (n == ack_lat) begin
          mem_bus.ack = 1'b1; mem_bus.rdata = rdata;
        end
      end
      if (wb_valid) begin
        o.wb_seen = 1'b1; o.lat = 8'(c); o.wb_data = wb_data; o.wb_rw = wb_regwrite;
        o.wb_reg = wb_reg; o.mis = exc_misaligned; o.bus = exc_bus;
        break;
      end
      @(posedge clk); #1;
    end
    o.req_cycles = 8'(n);
    mem_bus.ack = 1'b0;
    @(posedge clk); #1;
    if (wb_valid || exc_misaligned || exc_bus || mem_bus.req) o.pulse_ok = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 0; memread = 0; memwrite = 0; membyte = 0; alu_result = 0; data_store = 0;
    regwrite_in = 0; wreg_in = 0; mem_bus.ack = 0; mem_bus.rdata = 0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({mem_bus.req, mem_bus.we, mem_bus.be, mem_bus.addr, mem_bus.wdata} !== '0) begin
      failures++;
      $display("FAIL reset_membus: got req=%b we=%b be=%h addr=%h wdata=%h want all 0",
               mem_bus.req, mem_bus.we, mem_bus.be, mem_bus.addr, mem_bus.wdata);
    end
    checks++;
    if ({stall, wb_valid, wb_regwrite, wb_data, wb_reg, exc_misaligned, exc_bus} !== '0) begin
      failures++;
      $display("FAIL reset_wb: got stall=%b v=%b rw=%b data=%h reg=%0d mis=%b bus=%b want all 0",
               stall, wb_valid, wb_regwrite, wb_data, wb_reg, exc_misaligned, exc_bus);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem();
    res_t o;
    run_op(1'b0, 1'b0, 1'b0, 32'h1234, 32'hFFFF_0000, 32'h0, 1'b1, 5'd5, 0, 1'b1, o);
    checks++;
    if (o.lat !== 8'd1 || o.wb_seen !== 1'b1) begin
      failures++; $display("FAIL nonmem_latency: got %0d seen=%b want 1", o.lat, o.wb_seen);
    end
    checks++;
    if ({o.wb_data, o.wb_reg, o.wb_rw} !== {32'h1234, 5'd5, 1'b1}) begin
      failures++;
      $display("FAIL nonmem_wb: got data=%h reg=%0d rw=%b want 1234/5/1", o.wb_data, o.wb_reg,
               o.wb_rw);
    end
    checks++;
    if (o.stall_cycles !== 8'd0 || o.req_cycles !== 8'd0 || o.pulse_ok !== 1'b1) begin
      failures++;
      $display("FAIL nonmem_stall: got stall=%0d req=%0d pulse=%b want 0/0/1", o.stall_cycles,
               o.req_cycles, o.pulse_ok);
    end
  endtask

  task automatic test_word_load();
    res_t o;
    run_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd7, 3, 1'b0, o);
    checks++;
    if (o.req_cycles !== 8'd3 || o.stall_cycles !== 8'd3) begin
      failures++;
      $display("FAIL wload_cycles: got req=%0d stall=%0d want 3/3", o.req_cycles, o.stall_cycles);
    end
    checks++;
    if ({o.we, o.be, o.addr, o.stable} !== {1'b0, 4'hF, 32'h100, 1'b1}) begin
      failures++;
      $display("FAIL wload_bus: got we=%b be=%h addr=%h stable=%b want 0/f/100/1", o.we, o.be,
               o.addr, o.stable);
    end
    checks++;
    if ({o.wb_data, o.wb_rw, o.wb_reg, o.lat} !== {32'hDEAD_BEEF, 1'b1, 5'd7, 8'd4}) begin
      failures++;
      $display("FAIL wload_wb: got data=%h rw=%b reg=%0d lat=%0d want deadbeef/1/7/4",
               o.wb_data, o.wb_rw, o.wb_reg, o.lat);
    end
  endtask

  task automatic test_byte_store();
    res_t o;
    run_op(1'b0, 1'b1, 1'b1, 32'h103, 32'h0000_00A5, 32'h0, 1'b1, 5'd9, 2, 1'b0, o);
    checks++;
    if ({o.we, o.be, o.wdata, o.addr} !== {1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h100}) begin
      failures++;
      $display("FAIL bstore_bus: got we=%b be=%b wdata=%h addr=%h want 1/1000/a5a5a5a5/100",
               o.we, o.be, o.wdata, o.addr);
    end
    checks++;
    if ({o.wb_seen, o.wb_rw, o.wb_data, o.pulse_ok} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL bstore_wb: got seen=%b rw=%b data=%h pulse=%b want 1/0/0/1", o.wb_seen,
               o.wb_rw, o.wb_data, o.pulse_ok);
    end
  endtask

  task automatic test_byte_load();
    res_t o;
    run_op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'h0080_0000, 1'b1, 5'd3, 1, 1'b0, o);
    checks++;
    if ({o.wb_data, o.be} !== {32'hFFFF_FF80, 4'b0100}) begin
      failures++;
      $display("FAIL bload_neg: got data=%h be=%b want ffffff80/0100", o.wb_data, o.be);
    end
    run_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h1234_567F, 1'b1, 5'd3, 2, 1'b0, o);
    checks++;
    if (o.wb_data !== 32'h0000_007F) begin
      failures++; $display("FAIL bload_pos: got %h want 0000007f", o.wb_data);
    end
  endtask

  task automatic test_misaligned();
    res_t o;
    run_op(1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 5'd4, 1, 1'b0, o);
    checks++;
    if ({o.req_cycles, o.mis, o.bus, o.wb_rw, o.lat} !== {8'd0, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL misaligned: got req=%0d mis=%b bus=%b rw=%b lat=%0d want 0/1/0/0/1",
               o.req_cycles, o.mis, o.bus, o.wb_rw, o.lat);
    end
    // Read and write both set behaves as a load.
    run_op(1'b1, 1'b1, 1'b0, 32'h300, 32'h5555_5555, 32'hCAFE_F00D, 1'b1, 5'd8, 1, 1'b0, o);
    checks++;
    if ({o.we, o.wb_rw, o.wb_data} !== {1'b0, 1'b1, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL rdwr_as_load: got we=%b rw=%b data=%h want 0/1/cafef00d", o.we, o.wb_rw,
               o.wb_data);
    end
  endtask

  task automatic test_timeout();
    res_t o;
    run_op(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 5'd2, 0, 1'b0, o);
    checks++;
    if ({o.bus, o.mis, o.wb_rw, o.req_cycles, o.lat, o.pulse_ok} !==
        {1'b1, 1'b0, 1'b0, 8'(TO), 8'(TO + 1), 1'b1}) begin
      failures++;
      $display("FAIL timeout: got bus=%b mis=%b rw=%b req=%0d lat=%0d pulse=%b want 1/0/0/%0d/%0d/1",
               o.bus, o.mis, o.wb_rw, o.req_cycles, o.lat, o.pulse_ok, TO, TO + 1);
    end
    // Ack on the last allowed cycle beats the timeout.
    run_op(1'b1, 1'b0, 1'b0, 32'h404, 32'h0, 32'h0BAD_CAFE, 1'b1, 5'd2, TO, 1'b0, o);
    checks++;
    if ({o.bus, o.wb_data, o.wb_rw} !== {1'b0, 32'h0BAD_CAFE, 1'b1}) begin
      failures++;
      $display("FAIL ack_at_limit: got bus=%b data=%h rw=%b want 0/0badcafe/1", o.bus,
               o.wb_data, o.wb_rw);
    end
  endtask

  task automatic test_back_to_back();
    memread = 1'b1; memwrite = 1'b0; membyte = 1'b0; alu_result = 32'h40; regwrite_in = 1'b1;
    wreg_in = 5'd3; in_valid = 1'b1; mem_bus.ack = 1'b0;
    @(posedge clk); #1;
    alu_result = 32'h80; wreg_in = 5'd4;  // next instruction, held while stalled
    checks++;
    if ({mem_bus.req, stall, mem_bus.addr} !== {1'b1, 1'b1, 32'h40}) begin
      failures++;
      $display("FAIL b2b_first_req: got req=%b stall=%b addr=%h want 1/1/40", mem_bus.req,
               stall, mem_bus.addr);
    end
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'hA0A0_A0A0;
    @(posedge clk); #1;
    mem_bus.ack = 1'b0;
    checks++;
    if ({wb_valid, wb_data, stall, mem_bus.req} !== {1'b1, 32'hA0A0_A0A0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first_wb: got v=%b data=%h stall=%b req=%b want 1/a0a0a0a0/0/0",
               wb_valid, wb_data, stall, mem_bus.req);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({mem_bus.req, stall, mem_bus.addr, wb_valid} !== {1'b1, 1'b1, 32'h80, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second_req: got req=%b stall=%b addr=%h v=%b want 1/1/80/0",
               mem_bus.req, stall, mem_bus.addr, wb_valid);
    end
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h0B0B_0B0B;
    @(posedge clk); #1;
    mem_bus.ack = 1'b0;
    checks++;
    if ({wb_valid, wb_data, wb_reg} !== {1'b1, 32'h0B0B_0B0B, 5'd4}) begin
      failures++;
      $display("FAIL b2b_second_wb: got v=%b data=%h reg=%0d want 1/0b0b0b0b/4", wb_valid,
               wb_data, wb_reg);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    res_t o;
    res_t e;
    logic rd, wr, by, rw, junk;
    logic [31:0] addr, ds, rdata;
    logic [4:0] wreg;
    int sel, ack_lat;
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom); wr = 1'($urandom); by = 1'($urandom); rw = 1'($urandom);
      junk = 1'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
      ds = $urandom; rdata = $urandom; wreg = 5'($urandom);
      sel = int'($urandom_range(0, 9));
      ack_lat = (sel == 0) ? 0 : (sel == 1) ? TO : (sel == 2) ? TO + 1
                                                              : int'($urandom_range(1, 4));
      e = model(rd, wr, by, addr, ds, rdata, rw, wreg, ack_lat);
      run_op(rd, wr, by, addr, ds, rdata, rw, wreg, ack_lat, junk, o);
      // Fields left undefined by the stage's contract are not compared.
      if (e.mis || e.bus) o.wb_data = '0;
      if ((rd || wr) && !(rd && !e.mis && !e.bus)) o.wb_reg = '0;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random_op%0d: rd=%b wr=%b by=%b addr=%h ack=%0d got %h want %h", i, rd,
                 wr, by, addr, ack_lat, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    memread = 1'b1; memwrite = 1'b0; membyte = 1'b0; alu_result = 32'h500;
    regwrite_in = 1'b1; wreg_in = 5'd6; in_valid = 1'b1; mem_bus.ack = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req !== 1'b1) begin
      failures++; $display("FAIL rst_wait_pre: got req=%b want 1", mem_bus.req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_bus.req, stall} !== 2'b00) begin
      failures++;
      $display("FAIL rst_wait_drop: got req=%b stall=%b want 0/0", mem_bus.req, stall);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (wb_valid || mem_bus.req) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL rst_wait_after: got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
